// File: rtl/pcie_pio_avmm_arbiter.sv
// Two-master round-robin Avalon-MM arbiter in front of the PIO slave.
// One transaction in flight, fixed read latency, waitrequest timeout.
module pcie_pio_avmm_arbiter #(
  parameter int                ADDR_W       = 4,
  parameter int                DATA_W       = 32,
  parameter int                READ_LATENCY = 1,
  parameter int                TIMEOUT      = 255,
  parameter logic [DATA_W-1:0] ERR_DATA     = 32'hDEAD_BEEF
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     s_address,
  output logic                  s_read,
  output logic                  s_write,
  output logic [DATA_W-1:0]     s_writedata,
  output logic [DATA_W/8-1:0]   s_byteenable,
  input  logic                  s_waitrequest,
  input  logic [DATA_W-1:0]     s_readdata,
  output logic                  err_timeout,
  output logic                  err_master,
  input  logic                  err_clear
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);
  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ACK,
    S_RDWAIT,
    S_RESP
  } state_t;

  state_t state_q, state_d;
  logic grant_q, grant_d;
  logic last_q, last_d;
  logic rd_q, rd_d;
  logic abort_q, abort_d;
  logic [9:0] to_q, to_d;
  logic [2:0] lat_q, lat_d;
  logic [ADDR_W-1:0] sa_q, sa_d;
  logic [DATA_W-1:0] sd_q, sd_d;
  logic [BE_W-1:0] sbe_q, sbe_d;
  logic srd_q, srd_d;
  logic swr_q, swr_d;
  logic [DATA_W-1:0] rd0_q, rd0_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic err_q, err_d;
  logic errm_q, errm_d;

  logic req0, req1;
  logic gnt, g_wr, g_rd, take;
  logic [DATA_W-1:0] smp;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  assign gnt  = (req0 & req1) ? ~last_q : req1;
  assign g_wr = gnt ? m1_write : m0_write;
  assign g_rd = (gnt ? m1_read : m0_read) & ~g_wr;
  assign smp  = abort_q ? ERR_DATA : s_readdata;

  // Arbitration, command sequencing and response capture.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    rd_d    = rd_q;
    abort_d = abort_q;
    to_d    = to_q;
    lat_d   = lat_q;
    sa_d    = sa_q;
    sd_d    = sd_q;
    sbe_d   = sbe_q;
    srd_d   = srd_q;
    swr_d   = swr_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    err_d   = err_q;
    errm_d  = errm_q;
    take    = 1'b0;
    if (err_clear) err_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          grant_d = gnt;
          last_d  = gnt;
          sa_d    = gnt ? m1_address : m0_address;
          sd_d    = gnt ? m1_writedata : m0_writedata;
          sbe_d   = gnt ? m1_byteenable : m0_byteenable;
          swr_d   = g_wr;
          srd_d   = g_rd;
          rd_d    = g_rd;
          abort_d = 1'b0;
          to_d    = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!s_waitrequest) begin
          srd_d   = 1'b0;
          swr_d   = 1'b0;
          lat_d   = LAT;
          state_d = S_ACK;
        end else if (to_q == TO_LAST) begin
          srd_d   = 1'b0;
          swr_d   = 1'b0;
          lat_d   = LAT;
          abort_d = 1'b1;
          err_d   = 1'b1;
          errm_d  = grant_q;
          state_d = S_ACK;
        end else begin
          to_d = to_q + 10'd1;
        end
      end
      S_ACK: begin
        if (!rd_q) begin
          state_d = S_IDLE;
        end else if (lat_q == 3'd1) begin
          take    = 1'b1;
          state_d = S_RESP;
        end else begin
          lat_d   = lat_q - 3'd1;
          state_d = S_RDWAIT;
        end
      end
      S_RDWAIT: begin
        if (lat_q == 3'd1) begin
          take    = 1'b1;
          state_d = S_RESP;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (take) begin
      if (grant_q) rd1_d = smp;
      else rd0_d = smp;
    end
  end

  // State and datapath registers; reset abandons any transaction.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q <= S_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      rd_q    <= 1'b0;
      abort_q <= 1'b0;
      to_q    <= '0;
      lat_q   <= '0;
      sa_q    <= '0;
      sd_q    <= '0;
      sbe_q   <= '0;
      srd_q   <= 1'b0;
      swr_q   <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      err_q   <= 1'b0;
      errm_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      rd_q    <= rd_d;
      abort_q <= abort_d;
      to_q    <= to_d;
      lat_q   <= lat_d;
      sa_q    <= sa_d;
      sd_q    <= sd_d;
      sbe_q   <= sbe_d;
      srd_q   <= srd_d;
      swr_q   <= swr_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      err_q   <= err_d;
      errm_q  <= errm_d;
    end
  end

  assign m0_waitrequest   = !(state_q == S_ACK && !grant_q);
  assign m1_waitrequest   = !(state_q == S_ACK && grant_q);
  assign m0_readdatavalid = (state_q == S_RESP) && !grant_q;
  assign m1_readdatavalid = (state_q == S_RESP) && grant_q;
  assign m0_readdata      = rd0_q;
  assign m1_readdata      = rd1_q;
  assign s_address        = sa_q;
  assign s_writedata      = sd_q;
  assign s_byteenable     = sbe_q;
  assign s_read           = srd_q;
  assign s_write          = swr_q;
  assign err_timeout      = err_q;
  assign err_master       = errm_q;

endmodule

// File: tb/tb_pcie_pio_avmm_arbiter.sv
// Bench for pcie_pio_avmm_arbiter: directed table, corner sequences,
// and random traffic against a transaction-timeline reference model.
module tb_pcie_pio_avmm_arbiter;

  localparam int TO = 16;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
  localparam logic [5:0] IDL = 6'b110000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic [3:0] m0_address, m1_address, s_address;
  logic m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, s_writedata;
  logic [3:0] m0_byteenable, m1_byteenable, s_byteenable;
  logic m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata, s_readdata;
  logic m0_readdatavalid, m1_readdatavalid;
  logic s_read, s_write, s_waitrequest;
  logic err_timeout, err_master, err_clear;

  pcie_pio_avmm_arbiter #(
    .ADDR_W(4), .DATA_W(32), .READ_LATENCY(1),
    .TIMEOUT(TO), .ERR_DATA(ERRD)
  ) dut (
    .clk_clk(clk), .reset_reset(rst),
    .m0_address(m0_address), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata),
    .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read),
    .s_write(s_write), .s_writedata(s_writedata),
    .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata),
    .err_timeout(err_timeout), .err_master(err_master),
    .err_clear(err_clear)
  );

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] fl();
    return {m0_waitrequest, m1_waitrequest,
            m0_readdatavalid, m1_readdatavalid,
            s_read, s_write};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    m0_address = '0; m0_read = 0; m0_write = 0;
    m0_writedata = '0; m0_byteenable = 4'hF;
    m1_address = '0; m1_read = 0; m1_write = 0;
    m1_writedata = '0; m1_byteenable = 4'hF;
    s_waitrequest = 0; s_readdata = '0; err_clear = 0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct packed {
    logic [1:0]  m0rw;
    logic [3:0]  m0a;
    logic [31:0] m0d;
    logic [1:0]  m1rw;
    logic [3:0]  m1a;
    logic        sw;
    logic [31:0] srd;
    logic [5:0]  efl;
    logic [3:0]  esa;
    logic [31:0] esd;
    logic [31:0] erd1;
  } vec_t;

  function automatic vec_t v(
    input logic [1:0] m0rw, input logic [3:0] m0a,
    input logic [31:0] m0d, input logic [1:0] m1rw,
    input logic [3:0] m1a, input logic sw,
    input logic [31:0] srd, input logic [5:0] efl,
    input logic [3:0] esa, input logic [31:0] esd,
    input logic [31:0] erd1);
    vec_t r;
    r.m0rw = m0rw; r.m0a = m0a; r.m0d = m0d;
    r.m1rw = m1rw; r.m1a = m1a; r.sw = sw;
    r.srd = srd; r.efl = efl; r.esa = esa;
    r.esd = esd; r.erd1 = erd1;
    return r;
  endfunction

  vec_t tbl[15];

  // reference model state for the random phase
  int  free_at, tc, ta, tw;
  bit  tv, trd, tab, tg, lastg, cmd;
  bit  busy[2];
  logic [3:0] pa[2], pbe[2];
  logic [31:0] pd[2];
  bit  prd[2], pwr[2];
  logic [3:0] esa, esbe;
  logic [31:0] esd;
  logic [31:0] erd[2];
  logic eerr, eerrm;
  logic [5:0] e_fl;

  initial begin
    logic [3:0] order[$];
    int ack0, ack1, n;

    // --- directed table: write m0, read m1, stalled write m0
    tbl[0]  = v(2'b01, 4'h2, 32'hA, 2'b00, 4'h0, 0, 0, IDL, 4'h0, 32'h0, 0);
    tbl[1]  = v(2'b01, 4'h2, 32'hA, 2'b00, 4'h0, 0, 0, 6'b110001, 4'h2, 32'hA, 0);
    tbl[2]  = v(2'b01, 4'h2, 32'hA, 2'b00, 4'h0, 0, 0, 6'b010000, 4'h2, 32'hA, 0);
    tbl[3]  = v(2'b00, 4'h0, 32'h0, 2'b00, 4'h0, 0, 0, IDL, 4'h2, 32'hA, 0);
    tbl[4]  = v(2'b00, 4'h0, 32'h0, 2'b10, 4'h3, 0, 0, IDL, 4'h2, 32'hA, 0);
    tbl[5]  = v(2'b00, 4'h0, 32'h0, 2'b10, 4'h3, 0, 0, 6'b110010, 4'h3, 32'h0, 0);
    tbl[6]  = v(2'b00, 4'h0, 32'h0, 2'b10, 4'h3, 0, 5, 6'b100000, 4'h3, 32'h0, 0);
    tbl[7]  = v(2'b00, 4'h0, 32'h0, 2'b00, 4'h0, 0, 0, 6'b110100, 4'h3, 32'h0, 5);
    tbl[8]  = v(2'b01, 4'h1, 32'h77, 2'b00, 4'h0, 0, 0, IDL, 4'h3, 32'h0, 5);
    tbl[9]  = v(2'b01, 4'h1, 32'h77, 2'b00, 4'h0, 1, 0, 6'b110001, 4'h1, 32'h77, 5);
    tbl[10] = v(2'b01, 4'h1, 32'h77, 2'b00, 4'h0, 1, 0, 6'b110001, 4'h1, 32'h77, 5);
    tbl[11] = v(2'b01, 4'h1, 32'h77, 2'b00, 4'h0, 1, 0, 6'b110001, 4'h1, 32'h77, 5);
    tbl[12] = v(2'b01, 4'h1, 32'h77, 2'b00, 4'h0, 0, 0, 6'b110001, 4'h1, 32'h77, 5);
    tbl[13] = v(2'b01, 4'h1, 32'h77, 2'b00, 4'h0, 0, 0, 6'b010000, 4'h1, 32'h77, 5);
    tbl[14] = v(2'b00, 4'h0, 32'h0, 2'b00, 4'h0, 0, 0, IDL, 4'h1, 32'h77, 5);

    do_reset();
    for (int i = 0; i < 15; i++) begin
      m0_read = tbl[i].m0rw[1]; m0_write = tbl[i].m0rw[0];
      m0_address = tbl[i].m0a; m0_writedata = tbl[i].m0d;
      m1_read = tbl[i].m1rw[1]; m1_write = tbl[i].m1rw[0];
      m1_address = tbl[i].m1a;
      s_waitrequest = tbl[i].sw; s_readdata = tbl[i].srd;
      chk($sformatf("tbl%0d_ctl", i), fl(), tbl[i].efl);
      chk($sformatf("tbl%0d_sbus", i),
          {s_address, s_writedata}, {tbl[i].esa, tbl[i].esd});
      chk($sformatf("tbl%0d_rdata", i),
          {m0_readdata, m1_readdata}, {32'h0, tbl[i].erd1});
      chk($sformatf("tbl%0d_err", i),
          {err_timeout, err_master}, 2'b00);
      tick();
    end

    // --- continuous contention: 8 writes alternate m0,m1
    do_reset();
    m0_write = 1; m0_address = 4'hA; m0_writedata = 1;
    m1_write = 1; m1_address = 4'hB; m1_writedata = 2;
    ack0 = 0; ack1 = 0;
    for (int i = 0; i < 24; i++) begin
      if (s_write && !s_waitrequest) order.push_back(s_address);
      if (!m0_waitrequest) ack0++;
      if (!m1_waitrequest) ack1++;
      tick();
    end
    for (int i = 0; i < 8; i++)
      chk($sformatf("rr_order%0d", i),
          (i < order.size()) ? order[i] : 4'h0,
          (i % 2 == 1) ? 4'hB : 4'hA);
    chk("rr_ack0", ack0, 4);
    chk("rr_ack1", ack1, 4);

    // --- timeout on a stuck m1 read
    do_reset();
    m1_read = 1; m1_address = 4'h7; s_waitrequest = 1;
    for (int i = 0; i < 5 && !s_read; i++) tick();
    n = 0;
    while (s_read && n < 40) begin
      n++;
      tick();
    end
    chk("to_cycles", n, TO);
    chk("to_ack", {m1_waitrequest, m0_waitrequest}, 2'b01);
    chk("to_err", {err_timeout, err_master}, 2'b11);
    tick();
    m1_read = 0;
    chk("to_valid", {m0_readdatavalid, m1_readdatavalid}, 2'b01);
    chk("to_data", m1_readdata, ERRD);
    tick();
    chk("to_sticky", err_timeout, 1'b1);
    err_clear = 1;
    tick();
    err_clear = 0;
    chk("to_clear", {err_timeout, err_master}, 2'b01);

    // --- async reset while a read sits in ISSUE
    do_reset();
    m0_read = 1; m0_address = 4'h4; s_readdata = 32'h11;
    tick(); tick(); tick();
    m0_read = 0;
    chk("rs_pre_data", m0_readdata, 32'h11);
    tick();
    m0_read = 1; m0_address = 4'h9; s_waitrequest = 1;
    tick();
    chk("rs_issue", s_read, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rs_ctl", fl(), IDL);
    chk("rs_sbus", {s_address, s_writedata, s_byteenable}, '0);
    chk("rs_rdata", {m0_readdata, m1_readdata}, '0);
    chk("rs_err", {err_timeout, err_master}, 2'b00);
    idle_in();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rs_quiet%0d", i), fl(), IDL);
      tick();
    end
    m0_write = 1; m0_address = 4'h1;
    m1_write = 1; m1_address = 4'h2;
    tick();
    chk("rs_tie", {s_write, s_address}, {1'b1, 4'h1});
    idle_in();
    tick(); tick();

    // --- random traffic against the timeline model
    do_reset();
    free_at = 0; tv = 0; lastg = 1; tc = 0; ta = 0; tw = 0;
    trd = 0; tab = 0; tg = 0;
    busy[0] = 0; busy[1] = 0;
    esa = '0; esd = '0; esbe = '0;
    erd[0] = '0; erd[1] = '0; eerr = 0; eerrm = 0;
    for (int t = 0; t < 3000; t++) begin
      cmd = tv && t > tc && t <= ta;
      e_fl = {!(tv && t == ta + 1 && !tg),
              !(tv && t == ta + 1 && tg),
              tv && trd && t == ta + 2 && !tg,
              tv && trd && t == ta + 2 && tg,
              cmd && trd, cmd && !trd};
      chk("rnd_ctl", fl(), e_fl);
      chk("rnd_sbus", {s_address, s_writedata, s_byteenable},
          {esa, esd, esbe});
      chk("rnd_rdata", {m0_readdata, m1_readdata}, {erd[0], erd[1]});
      chk("rnd_err", {err_timeout, err_master}, {eerr, eerrm});

      for (int k = 0; k < 2; k++) begin
        if (!busy[k] && $urandom_range(0, 2) == 0) begin
          busy[k] = 1;
          pa[k] = 4'($urandom);
          pd[k] = $urandom;
          pbe[k] = 4'($urandom);
          case ($urandom_range(0, 2))
            0: begin prd[k] = 1; pwr[k] = 0; end
            1: begin prd[k] = 0; pwr[k] = 1; end
            default: begin prd[k] = 1; pwr[k] = 1; end
          endcase
        end
      end
      m0_read = busy[0] && prd[0];
      m0_write = busy[0] && pwr[0];
      m0_address = busy[0] ? pa[0] : 4'($urandom);
      m0_writedata = busy[0] ? pd[0] : $urandom;
      m0_byteenable = busy[0] ? pbe[0] : 4'($urandom);
      m1_read = busy[1] && prd[1];
      m1_write = busy[1] && pwr[1];
      m1_address = busy[1] ? pa[1] : 4'($urandom);
      m1_writedata = busy[1] ? pd[1] : $urandom;
      m1_byteenable = busy[1] ? pbe[1] : 4'($urandom);
      s_waitrequest = cmd ? (t - tc <= tw) : 1'($urandom);
      s_readdata = $urandom;
      err_clear = ($urandom_range(0, 15) == 0);

      if (err_clear) eerr = 0;
      if (tv && tab && t == ta) begin
        eerr = 1;
        eerrm = tg;
      end
      if (tv && t == ta + 1) begin
        busy[tg] = 0;
        if (trd) erd[tg] = tab ? ERRD : s_readdata;
      end
      if (t >= free_at && (busy[0] || busy[1])) begin
        tg = (busy[0] && busy[1]) ? !lastg : busy[1];
        lastg = tg;
        tv = 1;
        tc = t;
        trd = prd[tg] && !pwr[tg];
        tw = ($urandom_range(0, 9) == 0) ?
             $urandom_range(TO, TO + 4) : $urandom_range(0, 3);
        tab = (tw >= TO);
        ta = tab ? t + TO : t + 1 + tw;
        free_at = trd ? ta + 3 : ta + 2;
        esa = pa[tg];
        esd = pd[tg];
        esbe = pbe[tg];
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
